// File: rtl/pipe_vect_skid.sv
// Elastic stage register for the vector datapath: a main entry driving the
// outputs plus a skid entry, so in_ready comes straight from a flop.
// Captured operands have disabled lanes forced to zero.
//
// state | meaning
// EMPTY | nothing held, out_valid low
// ONE   | main holds the oldest beat, skid unused
// TWO   | main and skid both hold beats, in_ready low
module pipe_vect_skid #(
  parameter int CTRL_W       = 24,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int NUM_OPERANDS = 2
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     flush,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [CTRL_W-1:0]                                        in_ctrl,
  input  logic [NUM_OPERANDS-1:0][vectorSize-1:0][registerSize-1:0] in_vec,
  input  logic [vectorSize-1:0]                                    in_mask,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [CTRL_W-1:0]                                        out_ctrl,
  output logic [NUM_OPERANDS-1:0][vectorSize-1:0][registerSize-1:0] out_vec,
  output logic [vectorSize-1:0]                                    out_mask,
  output logic [1:0]                                               occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_e;

  skidState_e state;
  skidState_e stateNext;

  logic inReadyQ;
  logic push;
  logic pop;
  logic loadMainIn;
  logic loadMainSkid;
  logic loadSkid;

  logic [NUM_OPERANDS-1:0][vectorSize-1:0][registerSize-1:0] maskedVec;

  logic [CTRL_W-1:0]                                        mainCtrl;
  logic [NUM_OPERANDS-1:0][vectorSize-1:0][registerSize-1:0] mainVec;
  logic [vectorSize-1:0]                                    mainMask;
  logic [CTRL_W-1:0]                                        skidCtrl;
  logic [NUM_OPERANDS-1:0][vectorSize-1:0][registerSize-1:0] skidVec;
  logic [vectorSize-1:0]                                    skidMask;

  assign push = in_valid && inReadyQ;
  assign pop  = (state != EMPTY) && out_ready;

  // Zero every disabled lane of every operand before it is captured.
  always_comb begin
    maskedVec = '0;
    for (int op = 0; op < NUM_OPERANDS; op++) begin
      for (int lane = 0; lane < vectorSize; lane++) begin
        if (in_mask[lane]) begin
          maskedVec[op][lane] = in_vec[op][lane];
        end
      end
    end
  end

  // Next-state and data-load selection; flush overrides every transition.
  always_comb begin
    stateNext    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          stateNext  = ONE;
          loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          loadMainIn = 1'b1;
        end else if (push) begin
          stateNext = TWO;
          loadSkid  = 1'b1;
        end else if (pop) begin
          stateNext = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          stateNext    = ONE;
          loadMainSkid = 1'b1;
        end
      end
      default: begin
        stateNext = EMPTY;
      end
    endcase
    if (flush) begin
      // A pop on this edge still counts as taken; the data simply stays put.
      stateNext    = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // in_ready is its own flop so no input reaches it combinationally; it
  // stays low through reset and rises on the first edge afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inReadyQ <= 1'b0;
    end else begin
      inReadyQ <= (stateNext != TWO);
    end
  end

  // Main entry: refilled from the input or promoted from skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainCtrl <= '0;
      mainVec  <= '0;
      mainMask <= '0;
    end else if (loadMainIn) begin
      mainCtrl <= in_ctrl;
      mainVec  <= maskedVec;
      mainMask <= in_mask;
    end else if (loadMainSkid) begin
      mainCtrl <= skidCtrl;
      mainVec  <= skidVec;
      mainMask <= skidMask;
    end
  end

  // Skid entry: absorbs the one beat that arrives while main is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skidCtrl <= '0;
      skidVec  <= '0;
      skidMask <= '0;
    end else if (loadSkid) begin
      skidCtrl <= in_ctrl;
      skidVec  <= maskedVec;
      skidMask <= in_mask;
    end
  end

  // Occupancy encoding for the hazard logic.
  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = inReadyQ;
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = mainCtrl;
  assign out_vec   = mainVec;
  assign out_mask  = mainMask;

endmodule

// File: tb/tb_pipe_vect_skid.sv
// Directed and randomised bench for pipe_vect_skid: a default-size instance
// and a wide instance, both checked against queue scoreboards.
module tb_pipe_vect_skid;

  localparam int CW_A = 24, RS_A = 8,  VS_A = 4, NO_A = 2;
  localparam int CW_B = 18, RS_B = 16, VS_B = 8, NO_B = 3;

  typedef logic [NO_A-1:0][VS_A-1:0][RS_A-1:0] vecA_t;
  typedef logic [NO_B-1:0][VS_B-1:0][RS_B-1:0] vecB_t;
  typedef struct packed {logic [CW_A-1:0] ctrl; vecA_t vec; logic [VS_A-1:0] mask;} beatA_t;
  typedef struct packed {logic [CW_B-1:0] ctrl; vecB_t vec; logic [VS_B-1:0] mask;} beatB_t;

  logic clk;
  logic rst;

  logic            flushA, inValidA, inReadyA, outValidA, outReadyA;
  logic [CW_A-1:0] inCtrlA, outCtrlA;
  vecA_t           inVecA, outVecA;
  logic [VS_A-1:0] inMaskA, outMaskA;
  logic [1:0]      occA;

  logic            flushB, inValidB, inReadyB, outValidB, outReadyB;
  logic [CW_B-1:0] inCtrlB, outCtrlB;
  vecB_t           inVecB, outVecB;
  logic [VS_B-1:0] inMaskB, outMaskB;
  logic [1:0]      occB;

  int checks = 0;
  int fails  = 0;
  beatA_t qA[$];
  beatB_t qB[$];

  pipe_vect_skid dutA (
    .clk(clk), .rst(rst), .flush(flushA),
    .in_valid(inValidA), .in_ready(inReadyA), .in_ctrl(inCtrlA), .in_vec(inVecA), .in_mask(inMaskA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_ctrl(outCtrlA), .out_vec(outVecA), .out_mask(outMaskA),
    .occupancy(occA)
  );

  pipe_vect_skid #(.CTRL_W(CW_B), .registerSize(RS_B), .vectorSize(VS_B), .NUM_OPERANDS(NO_B)) dutB (
    .clk(clk), .rst(rst), .flush(flushB),
    .in_valid(inValidB), .in_ready(inReadyB), .in_ctrl(inCtrlB), .in_vec(inVecB), .in_mask(inMaskB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_ctrl(outCtrlB), .out_vec(outVecB), .out_mask(outMaskB),
    .occupancy(occB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vecA_t maskA(input vecA_t v, input logic [VS_A-1:0] m);
    vecA_t r;
    for (int op = 0; op < NO_A; op++)
      for (int l = 0; l < VS_A; l++)
        r[op][l] = m[l] ? v[op][l] : '0;
    return r;
  endfunction

  function automatic vecB_t maskB(input vecB_t v, input logic [VS_B-1:0] m);
    vecB_t r;
    for (int op = 0; op < NO_B; op++)
      for (int l = 0; l < VS_B; l++)
        r[op][l] = m[l] ? v[op][l] : '0;
    return r;
  endfunction

  function automatic vecB_t rndVecB();
    vecB_t r;
    for (int op = 0; op < NO_B; op++)
      for (int l = 0; l < VS_B; l++)
        r[op][l] = 16'($urandom);
    return r;
  endfunction

  // One cycle on instance A: drive at the falling edge, score push/pop,
  // then check status against the model at the next falling edge.
  task automatic stepA(input logic iv, input beatA_t b, input logic ordy, input logic fl,
                       output logic pushed);
    logic   pop, hold;
    beatA_t held, exp;
    inValidA = iv; inCtrlA = b.ctrl; inVecA = b.vec; inMaskA = b.mask;
    outReadyA = ordy; flushA = fl;
    #1;
    pushed = iv && inReadyA;
    pop    = outValidA && ordy;
    hold   = outValidA && !ordy && !fl;
    held   = {outCtrlA, outVecA, outMaskA};
    if (pop && qA.size() > 0) begin
      exp = qA.pop_front();
      chk("A_out_ctrl", outCtrlA, exp.ctrl);
      chk("A_out_vec",  outVecA,  exp.vec);
      chk("A_out_mask", outMaskA, exp.mask);
    end
    if (fl) qA.delete();
    else if (pushed) begin
      exp.ctrl = b.ctrl; exp.vec = maskA(b.vec, b.mask); exp.mask = b.mask;
      qA.push_back(exp);
    end
    @(posedge clk);
    @(negedge clk);
    chk("A_occupancy", occA, qA.size());
    chk("A_out_valid", outValidA, qA.size() != 0);
    chk("A_in_ready",  inReadyA,  qA.size() < 2);
    if (hold) chk("A_stall_stable", {outCtrlA, outVecA, outMaskA}, held);
  endtask

  task automatic stepB(input logic iv, input beatB_t b, input logic ordy, input logic fl,
                       output logic pushed);
    logic   pop, hold;
    beatB_t held, exp;
    inValidB = iv; inCtrlB = b.ctrl; inVecB = b.vec; inMaskB = b.mask;
    outReadyB = ordy; flushB = fl;
    #1;
    pushed = iv && inReadyB;
    pop    = outValidB && ordy;
    hold   = outValidB && !ordy && !fl;
    held   = {outCtrlB, outVecB, outMaskB};
    if (pop && qB.size() > 0) begin
      exp = qB.pop_front();
      chk("B_out_ctrl", outCtrlB, exp.ctrl);
      chk("B_out_vec",  outVecB,  exp.vec);
      chk("B_out_mask", outMaskB, exp.mask);
    end
    if (fl) qB.delete();
    else if (pushed) begin
      exp.ctrl = b.ctrl; exp.vec = maskB(b.vec, b.mask); exp.mask = b.mask;
      qB.push_back(exp);
    end
    @(posedge clk);
    @(negedge clk);
    chk("B_occupancy", occB, qB.size());
    chk("B_out_valid", outValidB, qB.size() != 0);
    chk("B_in_ready",  inReadyB,  qB.size() < 2);
    if (hold) chk("B_stall_stable", {outCtrlB, outVecB, outMaskB}, held);
  endtask

  initial begin
    beatA_t  a, bb, c, idle;
    beatB_t  bw, idleB;
    vecA_t   v;
    logic    p;
    int      cnt;

    idle = '0; idleB = '0;
    rst = 1'b0;
    flushA = 1'b0; inValidA = 1'b1; inCtrlA = 24'hABCDEF; inVecA = '1; inMaskA = '1; outReadyA = 1'b0;
    flushB = 1'b0; inValidB = 1'b0; inCtrlB = '0; inVecB = '0; inMaskB = '0; outReadyB = 1'b0;

    // Reset held with a pending beat: nothing may be taken or shown.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", outValidA, 1'b0);
    chk("rst_in_ready",  inReadyA,  1'b0);
    chk("rst_occupancy", occA,      2'd0);
    chk("rst_out_ctrl",  outCtrlA,  '0);
    chk("rst_out_vec",   outVecA,   '0);
    chk("rst_out_mask",  outMaskA,  '0);
    chk("rst_B_in_ready", inReadyB, 1'b0);
    rst = 1'b1;
    stepA(1'b0, idle, 1'b0, 1'b0, p);

    // Streaming, no bubbles.
    for (int i = 1; i <= 16; i++) begin
      a.ctrl = 24'(i); a.vec = {$urandom, $urandom}; a.mask = 4'($urandom);
      stepA(1'b1, a, 1'b1, 1'b0, p);
      chk("A_stream_accept", p, 1'b1);
    end
    stepA(1'b0, idle, 1'b1, 1'b0, p);

    // Backpressure: A, B fill the stage, C is refused until space opens.
    a.ctrl  = 24'h0000A0; a.vec  = {$urandom, $urandom}; a.mask  = 4'hF;
    bb.ctrl = 24'h0000B0; bb.vec = {$urandom, $urandom}; bb.mask = 4'hE;
    c.ctrl  = 24'h0000C0; c.vec  = {$urandom, $urandom}; c.mask  = 4'h7;
    stepA(1'b1, a,  1'b0, 1'b0, p);
    stepA(1'b1, bb, 1'b0, 1'b0, p);
    stepA(1'b1, c,  1'b0, 1'b0, p);
    chk("A_C_refused", p, 1'b0);
    stepA(1'b1, c,  1'b0, 1'b0, p);
    p = 1'b0;
    for (int i = 0; i < 8 && !p; i++) stepA(1'b1, c, 1'b1, 1'b0, p);
    chk("A_C_accepted", p, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepA(1'b0, idle, 1'b0, 1'b0, p);
      stepA(1'b0, idle, 1'b1, 1'b0, p);
    end

    // Lane mask: lanes 1 and 3 are dropped.
    v = '0; v[0] = {8'h11, 8'h22, 8'h33, 8'h44}; v[1] = 32'($urandom);
    a.ctrl = 24'h00005A; a.vec = v; a.mask = 4'b0101;
    stepA(1'b1, a, 1'b0, 1'b0, p);
    chk("A_mask_vec0", outVecA[0], 32'h00220044);
    chk("A_mask_bits", outMaskA, 4'b0101);
    stepA(1'b0, idle, 1'b1, 1'b0, p);

    // Flush collisions: with a pop in TWO, then with a push in EMPTY.
    a.ctrl  = 24'h000F01; a.vec  = {$urandom, $urandom}; a.mask  = 4'hF;
    bb.ctrl = 24'h000F02; bb.vec = {$urandom, $urandom}; bb.mask = 4'hF;
    c.ctrl  = 24'h000F03; c.vec  = {$urandom, $urandom}; c.mask  = 4'hF;
    stepA(1'b1, a,  1'b0, 1'b0, p);
    stepA(1'b1, bb, 1'b0, 1'b0, p);
    stepA(1'b0, idle, 1'b1, 1'b1, p);
    stepA(1'b1, c,  1'b0, 1'b1, p);
    c.ctrl = 24'h000F04;
    stepA(1'b1, c,  1'b1, 1'b0, p);
    stepA(1'b0, idle, 1'b1, 1'b0, p);

    // Asynchronous reset mid-operation with the stage full.
    stepA(1'b1, a,  1'b0, 1'b0, p);
    stepA(1'b1, bb, 1'b0, 1'b0, p);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", outValidA, 1'b0);
    chk("midrst_occupancy", occA,      2'd0);
    chk("midrst_in_ready",  inReadyA,  1'b0);
    qA.delete();
    inValidA = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stepA(1'b0, idle, 1'b0, 1'b0, p);

    // Wide instance: random valid/ready/flush against the scoreboard.
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      bw.ctrl = 18'(cnt); bw.vec = rndVecB(); bw.mask = 8'($urandom);
      stepB(1'($urandom_range(0, 1)), bw, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), p);
      if (p) cnt++;
    end
    for (int i = 0; i < 4; i++) stepB(1'b0, idleB, 1'b1, 1'b0, p);
    chk("B_drained", qB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
